// File: rtl/seq_pattern_tx_if.sv
// Handshake and serial-output bundle of seq_pattern_tx.
// The master side drives start/pattern/reps; the slave side is the transmitter.
interface seq_pattern_tx_if #(
  parameter int PAT_W = 4,
  parameter int REP_W = 4
);
  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [REP_W-1:0] reps;
  logic             ready;
  logic             out_bit;
  logic             bit_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, pattern, reps,
    input  ready, out_bit, bit_valid, busy, done
  );

  modport slave (
    input  start, pattern, reps,
    output ready, out_bit, bit_valid, busy, done
  );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: MSB-first, repeated reps times with GAP idle cycles between copies.
// Define SEQ_PARITY_EN to append an even-parity bit after every copy of the pattern.
module seq_pattern_tx #(
  parameter int PAT_W = 4,
  parameter int REP_W = 4,
  parameter int GAP   = 0
) (
  input  logic            clk,
  input  logic            rst,
  seq_pattern_tx_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

  localparam int IW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [PAT_W-1:0] shreg_q, shreg_d;
  logic [IW-1:0]    bit_idx_q, bit_idx_d;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic             last_bit;
`ifdef SEQ_PARITY_EN
  logic             par_q, par_d;
`endif

  logic ready_q, ready_d;
  logic out_bit_q, out_bit_d;
  logic bit_valid_q, bit_valid_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pat_q       <= '0;
      shreg_q     <= '0;
      bit_idx_q   <= '0;
      rep_cnt_q   <= '0;
      gap_cnt_q   <= '0;
`ifdef SEQ_PARITY_EN
      par_q       <= 1'b0;
`endif
      ready_q     <= 1'b1;
      out_bit_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      shreg_q     <= shreg_d;
      bit_idx_q   <= bit_idx_d;
      rep_cnt_q   <= rep_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
`ifdef SEQ_PARITY_EN
      par_q       <= par_d;
`endif
      ready_q     <= ready_d;
      out_bit_q   <= out_bit_d;
      bit_valid_q <= bit_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // The bit currently on the line is the one this cycle ends; with parity that is the parity slot.
`ifdef SEQ_PARITY_EN
  assign last_bit = par_q;
`else
  assign last_bit = (bit_idx_q == '0);
`endif

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    shreg_d   = shreg_q;
    bit_idx_d = bit_idx_q;
    rep_cnt_d = rep_cnt_q;
    gap_cnt_d = gap_cnt_q;
`ifdef SEQ_PARITY_EN
    par_d     = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          pat_d     = bus.pattern;
          shreg_d   = bus.pattern;
          bit_idx_d = IW'(PAT_W - 1);
          rep_cnt_d = (bus.reps == '0) ? REP_W'(1) : bus.reps;
`ifdef SEQ_PARITY_EN
          par_d     = 1'b0;
`endif
          state_d   = S_SEND;
        end
      end
      S_SEND: begin
        if (last_bit) begin
`ifdef SEQ_PARITY_EN
          par_d = 1'b0;
`endif
          if (rep_cnt_q > REP_W'(1)) begin
            // Reload from the captured copy so later pattern input changes cannot leak in.
            rep_cnt_d = rep_cnt_q - REP_W'(1);
            shreg_d   = pat_q;
            bit_idx_d = IW'(PAT_W - 1);
            if (GAP > 0) begin
              state_d   = S_GAP;
              gap_cnt_d = GW'(GAP - 1);
            end
          end else begin
            state_d = S_DONE;
          end
        end
`ifdef SEQ_PARITY_EN
        else if (bit_idx_q == '0) begin
          par_d = 1'b1;
        end
`endif
        else begin
          shreg_d   = shreg_q << 1;
          bit_idx_d = bit_idx_q - IW'(1);
        end
      end
      S_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = S_SEND;
        end else begin
          gap_cnt_d = gap_cnt_q - GW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so the first bit follows the accept edge.
  always_comb begin
    ready_d     = (state_d == S_IDLE);
    busy_d      = (state_d == S_SEND) || (state_d == S_GAP);
    done_d      = (state_d == S_DONE);
    bit_valid_d = (state_d == S_SEND);
    out_bit_d   = 1'b0;
    if (state_d == S_SEND) begin
      out_bit_d = shreg_d[PAT_W-1];
`ifdef SEQ_PARITY_EN
      if (par_d) out_bit_d = ^pat_d;
`endif
    end
  end

  assign bus.ready     = ready_q;
  assign bus.out_bit   = out_bit_q;
  assign bus.bit_valid = bit_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: a GAP=0 and a GAP=2 instance share one stimulus,
// and each cycle's outputs are encoded as one symbol and compared as a stream.
module tb_seq_pattern_tx;
`ifdef SEQ_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] pattern;
  logic [3:0] reps;
  int         n_tests;
  int         n_fail;

  seq_pattern_tx_if #(.PAT_W(4), .REP_W(4)) if0 ();
  seq_pattern_tx_if #(.PAT_W(4), .REP_W(4)) if2 ();

  assign if0.start   = start;
  assign if0.pattern = pattern;
  assign if0.reps    = reps;
  assign if2.start   = start;
  assign if2.pattern = pattern;
  assign if2.reps    = reps;

  seq_pattern_tx #(.PAT_W(4), .REP_W(4), .GAP(0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  seq_pattern_tx #(.PAT_W(4), .REP_W(4), .GAP(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input string got, input string exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %s, expected %s", tag, got, exp);
    end else begin
      $display("[TB] %s ok: %s", tag, got);
    end
  endtask

  // 1/0 = valid bit, g = gap, D = done pulse, . = idle and ready, ? = illegal output combination
  function automatic string sym(input logic rdy, input logic ob, input logic bv,
                                input logic bsy, input logic dn);
    if (dn) return (!rdy && !bsy && !bv && !ob) ? "D" : "?";
    if (bv) return (bsy && !rdy) ? (ob ? "1" : "0") : "?";
    if (ob) return "?";
    if (bsy) return rdy ? "?" : "g";
    return rdy ? "." : "?";
  endfunction

  function automatic string frame(input logic [3:0] p);
    string s;
    s = "";
    for (int i = 3; i >= 0; i--) s = {s, p[i] ? "1" : "0"};
    if (PAR) s = {s, (^p) ? "1" : "0"};
    return s;
  endfunction

  task automatic start_tx(input logic [3:0] p, input logic [3:0] r);
    @(negedge clk);
    start   = 1'b1;
    pattern = p;
    reps    = r;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // poke_kind 1: stray start with new pattern/reps; 2: one-cycle reset
  task automatic run_stream(input string tag, input string e0, input string e2,
                            input int poke_at, input int poke_kind);
    string g0, g2;
    int    n;
    g0 = "";
    g2 = "";
    n  = (e0.len() > e2.len()) ? e0.len() : e2.len();
    while (e0.len() < n) e0 = {e0, "."};
    while (e2.len() < n) e2 = {e2, "."};
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      g0 = {g0, sym(if0.ready, if0.out_bit, if0.bit_valid, if0.busy, if0.done)};
      g2 = {g2, sym(if2.ready, if2.out_bit, if2.bit_valid, if2.busy, if2.done)};
      start = 1'b0;
      rst   = 1'b0;
      if (i == poke_at) begin
        if (poke_kind == 1) begin
          start   = 1'b1;
          pattern = 4'b0000;
          reps    = 4'd5;
        end else begin
          rst = 1'b1;
        end
      end
    end
    start = 1'b0;
    rst   = 1'b0;
    check({tag, "_gap0"}, g0, e0);
    check({tag, "_gap2"}, g2, e2);
  endtask

  initial begin
    string f, e0, e2;
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    start   = 1'b0;
    pattern = 4'b0000;
    reps    = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready0",  $sformatf("%b", if0.ready),     "1");
    check("rst_out0",    $sformatf("%b", if0.out_bit),   "0");
    check("rst_valid0",  $sformatf("%b", if0.bit_valid), "0");
    check("rst_busy0",   $sformatf("%b", if0.busy),      "0");
    check("rst_done0",   $sformatf("%b", if0.done),      "0");
    check("rst_ready2",  $sformatf("%b", if2.ready),     "1");
    check("rst_valid2",  $sformatf("%b", if2.bit_valid), "0");
    check("rst_busy2",   $sformatf("%b", if2.busy),      "0");
    rst = 1'b0;

    f = frame(4'b1011);
    start_tx(4'b1011, 4'd1);
    run_stream("single", {f, "D."}, {f, "D."}, -1, 0);

    start_tx(4'b1011, 4'd2);
    run_stream("rep2", {f, f, "D."}, {f, "gg", f, "D."}, -1, 0);

    f = frame(4'b1101);
    start_tx(4'b1101, 4'd3);
    run_stream("ignored_start", {f, f, f, "D."}, {f, "gg", f, "gg", f, "D."}, 1, 1);

    f = frame(4'b0110);
    start_tx(4'b0110, 4'd0);
    run_stream("reps0", {f, "D."}, {f, "D."}, -1, 0);

    f = frame(4'b1001);
    start_tx(4'b1001, 4'd1);
    run_stream("pat1001", {f, "D."}, {f, "D."}, -1, 0);

    f  = frame(4'b1000);
    e0 = "";
    e2 = "";
    for (int i = 0; i < 15; i++) begin
      e0 = {e0, f};
      e2 = {e2, f};
      if (i < 14) e2 = {e2, "gg"};
    end
    start_tx(4'b1000, 4'd15);
    run_stream("reps_max", {e0, "D."}, {e2, "D."}, -1, 0);

    start_tx(4'b1011, 4'd2);
    run_stream("rst_mid_send", "10....", "10....", 1, 2);

    f = frame(4'b1011);
    start_tx(4'b1011, 4'd1);
    run_stream("after_rst", {f, "D."}, {f, "D."}, -1, 0);

    start_tx(4'b1011, 4'd2);
    run_stream("rst_mid_gap", {f, "1...."}, {f, "g...."}, f.len(), 2);

    @(negedge clk);
    start   = 1'b1;
    rst     = 1'b1;
    pattern = 4'b1011;
    reps    = 4'd1;
    run_stream("rst_wins", "....", "....", -1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
